// File: rtl/urp_pcie_pkg.sv
// Shared constants and types for the PCIe receive/transmit data link layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: frame/DLLP field widths, DLLP type codes, LCRC polynomial and
// seed, RX link-layer FSM state encoding, and a DLLP packing helper.
package urp_pcie_pkg;

  localparam int SEQ_W    = 12;
  localparam int TLP_W    = 224;
  localparam int LCRC_W   = 32;
  localparam int FRAME_W  = 268;
  localparam int DLLP_W   = 32;
  // The LCRC covers the sequence number and the TLP body.
  localparam int CRC_IN_W = SEQ_W + TLP_W;

  localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
  localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

  localparam logic [LCRC_W-1:0] LCRC_POLY = 32'h04C1_1DB7;
  localparam logic [LCRC_W-1:0] LCRC_INIT = 32'hFFFF_FFFF;

  // Half the sequence space: anything this far behind (or less) is a replay.
  localparam logic [SEQ_W-1:0] DUP_WINDOW = 12'd2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FWD   = 2'd2,
    ST_DLLP  = 2'd3
  } rx_state_e;

  function automatic logic [DLLP_W-1:0] mk_dllp(input logic [7:0]       typ,
                                                 input logic [SEQ_W-1:0] seq);
    return {typ, 12'h000, seq};
  endfunction

endpackage

// File: rtl/urp_pcie_rx_data_link_layer_if.sv
// Handshake bundle between the link, the RX DLL, the transaction layer and the DLLP path.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every channel; data held while valid.
//
// Channels: framed TLP in (tlp_data_*), TLP out (tlp_*), DLLP out (dllp_*).
// 'slave' is the RX data link layer's view, 'master' the surrounding logic's.
interface urp_pcie_rx_data_link_layer_if;
  import urp_pcie_pkg::*;

  logic [FRAME_W-1:0] tlp_data_i;
  logic               tlp_data_valid_i;
  logic               tlp_data_ready_o;

  logic [TLP_W-1:0]   tlp_o;
  logic               tlp_valid_o;
  logic               tlp_ready_i;

  logic [DLLP_W-1:0]  dllp_o;
  logic               dllp_valid_o;
  logic               dllp_ready_i;

  modport slave (
    input  tlp_data_i, tlp_data_valid_i, tlp_ready_i, dllp_ready_i,
    output tlp_data_ready_o, tlp_o, tlp_valid_o, dllp_o, dllp_valid_o
  );

  modport master (
    output tlp_data_i, tlp_data_valid_i, tlp_ready_i, dllp_ready_i,
    input  tlp_data_ready_o, tlp_o, tlp_valid_o, dllp_o, dllp_valid_o
  );

endinterface

// File: rtl/urp_pcie_lcrc32.sv
// Combinational LCRC-32 (poly 04C11DB7, seed all-ones, MSB first, unreflected, inverted out).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
//
// Ports: data_i [235:0] = {seq, tlp}, bit 235 shifted in first; crc_o [31:0].
// Shared by the RX checker and the TX generator so both ends agree bit-for-bit.
module urp_pcie_lcrc32
  import urp_pcie_pkg::*;
(
  input  logic [CRC_IN_W-1:0] data_i,
  output logic [LCRC_W-1:0]   crc_o
);

  logic [LCRC_W-1:0] crc_v;
  logic              fb;

  // Serial shift-register form, unrolled by synthesis into an XOR tree.
  always_comb begin
    crc_v = LCRC_INIT;
    fb    = 1'b0;
    for (int i = CRC_IN_W - 1; i >= 0; i--) begin
      fb    = crc_v[LCRC_W-1] ^ data_i[i];
      crc_v = {crc_v[LCRC_W-2:0], 1'b0} ^ (fb ? LCRC_POLY : '0);
    end
    crc_o = ~crc_v;
  end

endmodule

// File: rtl/urp_pcie_rx_data_link_layer.sv
// RX data link layer: LCRC/sequence check, TLP forwarding, ACK/NAK DLLP return.
// Latency: accept -> CHECK (1) -> TLP valid (2); ACK valid the cycle after the TLP handshake.
// Backpressure: one frame in flight; input ready only in IDLE, FWD/DLLP stall indefinitely.
//
// Ports: clk, rst_n (async, active-low); rx (slave modport) carries the framed
// input, the TLP output and the DLLP output; lcrc_err_cnt_o is a saturating
// count of LCRC failures.
module urp_pcie_rx_data_link_layer
  import urp_pcie_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  urp_pcie_rx_data_link_layer_if.slave  rx,
  output logic [7:0]                    lcrc_err_cnt_o
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] CHECK = ST_CHECK;
  localparam logic [1:0] FWD   = ST_FWD;
  localparam logic [1:0] DLLP  = ST_DLLP;

  logic [1:0]         state_q,        state_d;
  logic [FRAME_W-1:0] frame_q,        frame_d;
  logic [SEQ_W-1:0]   next_rcv_seq_q, next_rcv_seq_d;
  logic               nak_sched_q,    nak_sched_d;
  logic [TLP_W-1:0]   tlp_q,          tlp_d;
  logic [DLLP_W-1:0]  dllp_q,         dllp_d;
  logic [7:0]         err_cnt_q,      err_cnt_d;

  // Held-frame fields.
  logic [SEQ_W-1:0]   frm_seq;
  logic [TLP_W-1:0]   frm_tlp;
  logic [LCRC_W-1:0]  frm_lcrc;
  logic [LCRC_W-1:0]  crc_calc;

  logic               lcrc_ok;
  logic [SEQ_W-1:0]   seq_diff;
  logic [SEQ_W-1:0]   last_good_seq;
  logic               is_dup;

  assign frm_seq  = frame_q[FRAME_W-1 -: SEQ_W];
  assign frm_tlp  = frame_q[LCRC_W +: TLP_W];
  assign frm_lcrc = frame_q[LCRC_W-1:0];

  urp_pcie_lcrc32 u_lcrc (
    .data_i (frame_q[FRAME_W-1:LCRC_W]),
    .crc_o  (crc_calc)
  );

  assign lcrc_ok = (crc_calc == frm_lcrc);

  // Modulo-4096 distance behind the expected sequence number. Zero means
  // in-order; 1..2048 is a replay of something already accepted; the
  // remaining half of the space is treated as a future (lost-frame) seq.
  assign seq_diff      = next_rcv_seq_q - frm_seq;
  assign last_good_seq = next_rcv_seq_q - 12'd1;   // 12'hFFF straight after reset
  assign is_dup        = (seq_diff != '0) && (seq_diff <= DUP_WINDOW);

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    next_rcv_seq_d = next_rcv_seq_q;
    nak_sched_d    = nak_sched_q;
    tlp_d          = tlp_q;
    dllp_d         = dllp_q;
    err_cnt_d      = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (rx.tlp_data_valid_i) begin
          frame_d = rx.tlp_data_i;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (!lcrc_ok) begin
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          // Only one NAK outstanding until a good in-order frame arrives.
          if (!nak_sched_q) begin
            nak_sched_d = 1'b1;
            dllp_d      = mk_dllp(DLLP_TYPE_NAK, last_good_seq);
            state_d     = DLLP;
          end else begin
            state_d     = IDLE;
          end
        end else if (frm_seq == next_rcv_seq_q) begin
          nak_sched_d = 1'b0;
          tlp_d       = frm_tlp;
          state_d     = FWD;
        end else if (is_dup) begin
          // Replay of an accepted frame: re-acknowledge so the TX side can purge.
          dllp_d  = mk_dllp(DLLP_TYPE_ACK, last_good_seq);
          state_d = DLLP;
        end else begin
          if (!nak_sched_q) begin
            nak_sched_d = 1'b1;
            dllp_d      = mk_dllp(DLLP_TYPE_NAK, last_good_seq);
            state_d     = DLLP;
          end else begin
            state_d     = IDLE;
          end
        end
      end

      FWD: begin
        if (rx.tlp_ready_i) begin
          // In FWD the held seq equals next_rcv_seq_q by construction.
          next_rcv_seq_d = next_rcv_seq_q + 12'd1;
          dllp_d         = mk_dllp(DLLP_TYPE_ACK, next_rcv_seq_q);
          state_d        = DLLP;
        end
      end

      DLLP: begin
        if (rx.dllp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      frame_q        <= '0;
      next_rcv_seq_q <= '0;
      nak_sched_q    <= 1'b0;
      tlp_q          <= '0;
      dllp_q         <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      next_rcv_seq_q <= next_rcv_seq_d;
      nak_sched_q    <= nak_sched_d;
      tlp_q          <= tlp_d;
      dllp_q         <= dllp_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  // Valids decode straight from the registered state, so they cannot glitch
  // or drop without the matching ready; the data registers only change on
  // the transition into the state that presents them.
  assign rx.tlp_data_ready_o = (state_q == IDLE);
  assign rx.tlp_valid_o      = (state_q == FWD);
  assign rx.tlp_o            = tlp_q;
  assign rx.dllp_valid_o     = (state_q == DLLP);
  assign rx.dllp_o           = dllp_q;
  assign lcrc_err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_urp_pcie_rx_data_link_layer.sv
// Scoreboard bench for the RX data link layer: stimulus pushes expected TLPs/DLLPs,
// monitors pop and compare on each output handshake.
// Backpressure on both outputs is exercised in the stall scenarios.
module tb_urp_pcie_rx_data_link_layer;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] lcrc_err_cnt;

  always #5 clk = ~clk;

  urp_pcie_rx_data_link_layer_if rx_if ();

  urp_pcie_rx_data_link_layer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx_if.slave),
    .lcrc_err_cnt_o (lcrc_err_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [223:0] exp_tlp[$];
  logic [31:0]  exp_dllp[$];
  logic [223:0] mon_tlp_e;
  logic [31:0]  mon_dllp_e;

  function automatic logic [223:0] mk_tlp(input logic [11:0] s);
    return {7{20'hC0DE5, s}};
  endfunction

  // Reference LCRC used only to build well-formed frames.
  function automatic logic [31:0] crc236(input logic [235:0] d);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 235; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return ~c;
  endfunction

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitors: compare on the edge where the handshake is about to complete.
  always @(negedge clk) begin
    if (rst_n && rx_if.tlp_valid_o && rx_if.tlp_ready_i) begin
      if (exp_tlp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tlp_unexpected: got=%h expected=none", rx_if.tlp_o);
      end else begin
        mon_tlp_e = exp_tlp.pop_front();
        chk("tlp", rx_if.tlp_o, mon_tlp_e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rx_if.dllp_valid_o && rx_if.dllp_ready_i) begin
      if (exp_dllp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dllp_unexpected: got=%h expected=none", rx_if.dllp_o);
      end else begin
        mon_dllp_e = exp_dllp.pop_front();
        chk("dllp", {192'h0, rx_if.dllp_o}, {192'h0, mon_dllp_e});
      end
    end
  end

  task automatic send_frame(input logic [11:0] seq, input bit corrupt);
    logic [235:0] body;
    logic [31:0]  crc;
    int           n;
    body = {seq, mk_tlp(seq)};
    crc  = crc236(body);
    if (corrupt) crc[0] = ~crc[0];
    @(negedge clk);
    rx_if.tlp_data_i       = {body, crc};
    rx_if.tlp_data_valid_i = 1'b1;
    n = 0;
    while (!rx_if.tlp_data_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: seq=%0d ready=0 expected=1", seq);
    end
    @(posedge clk);
    #1;
    rx_if.tlp_data_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_tlp.size() != 0 || exp_dllp.size() != 0 || !rx_if.tlp_data_ready_o) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: pending tlp=%0d dllp=%0d expected=0", name, exp_tlp.size(), exp_dllp.size());
    end
  endtask

  task automatic do_reset();
    rst_n                  = 1'b0;
    rx_if.tlp_data_valid_i = 1'b0;
    rx_if.tlp_ready_i      = 1'b1;
    rx_if.dllp_ready_i     = 1'b1;
    exp_tlp.delete();
    exp_dllp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic good(input logic [11:0] seq);
    exp_tlp.push_back(mk_tlp(seq));
    exp_dllp.push_back({20'h0, seq});
    send_frame(seq, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_ready"}, rx_if.tlp_data_ready_o, 1'b1);
    chk({tag, "_tlp_valid"},  rx_if.tlp_valid_o,      1'b0);
    chk({tag, "_tlp"},        rx_if.tlp_o,            224'h0);
    chk({tag, "_dllp_valid"}, rx_if.dllp_valid_o,     1'b0);
    chk({tag, "_dllp"},       rx_if.dllp_o,           224'h0);
    chk({tag, "_err_cnt"},    lcrc_err_cnt,           224'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rx_if.tlp_data_i = '0;
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");

    // In-order frames 0,1,2.
    good(12'd0);
    good(12'd1);
    good(12'd2);
    drain("inorder");

    // Bad LCRC: NAK of seq 0 for corrupted seq 1.
    do_reset();
    good(12'd0);
    exp_dllp.push_back(32'h1000_0000);
    send_frame(12'd1, 1'b1);
    drain("badlcrc");
    chk("badlcrc_cnt", lcrc_err_cnt, 224'd1);

    // NAK suppression, then recovery.
    send_frame(12'd1, 1'b1);
    drain("naksupp");
    chk("naksupp_cnt", lcrc_err_cnt, 224'd2);
    good(12'd1);
    drain("recover");
    chk("recover_cnt", lcrc_err_cnt, 224'd2);

    // Duplicate and future sequence numbers.
    do_reset();
    for (int i = 0; i < 5; i++) good(i[11:0]);
    exp_dllp.push_back(32'h0000_0004);
    send_frame(12'd2, 1'b0);
    exp_dllp.push_back(32'h1000_0004);
    send_frame(12'd9, 1'b0);
    send_frame(12'd9, 1'b0);          // NAK already scheduled: silent drop
    drain("dupfut");
    chk("dupfut_cnt", lcrc_err_cnt, 224'd0);

    // DLLP backpressure on in-order seq 5.
    rx_if.dllp_ready_i = 1'b0;
    exp_tlp.push_back(mk_tlp(12'd5));
    exp_dllp.push_back(32'h0000_0005);
    send_frame(12'd5, 1'b0);
    n = 0;
    while (!rx_if.dllp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("dstall_valid", rx_if.dllp_valid_o, 1'b1);
      chk("dstall_dllp",  rx_if.dllp_o, 224'h5);
      chk("dstall_ready", rx_if.tlp_data_ready_o, 1'b0);
    end
    rx_if.dllp_ready_i = 1'b1;
    drain("dstall");

    // Saturating error counter; first NAK after reset carries 12'hFFF.
    do_reset();
    exp_dllp.push_back(32'h1000_0FFF);
    for (int i = 0; i < 260; i++) send_frame(i[11:0], 1'b1);
    drain("sat");
    chk("sat_cnt", lcrc_err_cnt, 224'd255);

    // Sequence wrap: 4096 frames, then seq 0 in order again.
    do_reset();
    for (int i = 0; i < 4096; i++) good(i[11:0]);
    drain("wrap_fill");
    good(12'd0);
    drain("wrap");

    // TLP stall then reset mid-stall.
    do_reset();
    rx_if.tlp_ready_i = 1'b0;
    send_frame(12'd0, 1'b0);
    n = 0;
    while (!rx_if.tlp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("tstall_valid", rx_if.tlp_valid_o, 1'b1);
      chk("tstall_tlp",   rx_if.tlp_o, mk_tlp(12'd0));
      chk("tstall_ready", rx_if.tlp_data_ready_o, 1'b0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rx_if.tlp_ready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    good(12'd0);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/urp_pcie_rx_data_link_layer.md
# urp_pcie_rx_data_link_layer

Receive-side PCIe data link layer. It accepts 268-bit framed TLPs arriving from the link: a 12-bit sequence number, a 224-bit TLP and a 32-bit LCRC. It checks the LCRC and the sequence number, forwards good TLPs to the RX transaction layer, and returns ACK/NAK DLLPs to the remote transmitter's data link layer. It is the peer of the TX data link layer and consumes exactly the frame format that block produces.

## Interface
Parameters:
- none; all widths come from `urp_pcie_pkg` constants.

Ports (clock and reset first). Clock is `clk`; reset is `rst_n`, asynchronous, active-low.
- `clk`  in  1  single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `tlp_data_i`  in  268  framed TLP:
  - [267:256] sequence number
  - [255:32] TLP
  - [31:0] LCRC
- `tlp_data_valid_i`  in  1  frame valid
- `tlp_data_ready_o`  out  1  frame accepted when valid & ready
- `tlp_o`  out  224  TLP to the RX transaction layer
- `tlp_valid_o`  out  1  TLP valid
- `tlp_ready_i`  in  1  transaction layer accepts the TLP
- `dllp_o`  out  32  DLLP:
  - [31:24] type: 8'h00 ACK, 8'h10 NAK
  - [23:12] zero
  - [11:0] AckNak_Seq_Num
- `dllp_valid_o`  out  1  DLLP valid
- `dllp_ready_i`  in  1  DLLP accepted
- `lcrc_err_cnt_o`  out  8  saturating count of LCRC failures

## Operation
- State `next_rcv_seq` (12 bit, reset 0), flag `nak_sched` (reset 0), FSM states IDLE, CHECK, FWD, DLLP.
- **IDLE:** `tlp_data_ready_o`=1. On handshake, register the frame → CHECK.
- **CHECK:** one cycle. Compute CRC-32 over bits [267:32]:
  - polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB first, no reflection, final XOR 0xFFFFFFFF
  - compare the result with [31:0].
- Classification, first match wins:
  - **LCRC mismatch:**
    - `lcrc_err_cnt_o`++, saturating at 255.
    - If `!nak_sched`: set `nak_sched`, queue NAK(`next_rcv_seq`-1) → DLLP.
    - Otherwise → IDLE, frame dropped.
  - **seq == `next_rcv_seq`:** clear `nak_sched` → FWD.
  - **Duplicate**, i.e. (`next_rcv_seq` - seq) mod 4096 in [1, 2048]: drop, queue ACK(`next_rcv_seq`-1) → DLLP.
  - **Otherwise (future seq):** NAK handling identical to the LCRC-mismatch case, without touching the counter.
- **FWD:**
  - Drive `tlp_valid_o`=1 with `tlp_o`=frame[255:32], held stable until `tlp_ready_i`.
  - On handshake: `next_rcv_seq`++ (wraps 4095→0), queue ACK(seq) → DLLP.
- **DLLP:** `dllp_valid_o`=1, `dllp_o` held stable until `dllp_ready_i` → IDLE.
- Arithmetic: all sequence math is modulo 4096. The NAK/ACK field after reset with no good TLP is 12'hFFF.

## Timing
- Reset values:
  - `tlp_data_ready_o`=1 (IDLE)
  - `tlp_valid_o`=0, `tlp_o`=0
  - `dllp_valid_o`=0, `dllp_o`=0
  - `lcrc_err_cnt_o`=0
- Good frame accepted at edge N:
  - CHECK is cycle N+1.
  - `tlp_valid_o` is high from cycle N+2.
  - The ACK is valid the cycle after the TLP handshake.
- Minimum occupancy per good frame is 4 cycles (accept, CHECK, FWD, DLLP). `tlp_data_ready_o` is low in every state except IDLE.
- Backpressure: `tlp_ready_i`=0 stalls in FWD indefinitely, and `dllp_ready_i`=0 stalls in DLLP indefinitely. No input is accepted during either stall.
- Valid outputs never drop without a handshake, and their data stays constant while valid.
- Reset asserted mid-operation: immediate return to IDLE. The held frame, any pending TLP and any pending DLLP are discarded, and all state returns to its reset value.
- Counter wrap: a good frame with seq 4095 sets `next_rcv_seq`=0 and sends ACK(4095).

## Structure
- `urp_pcie_pkg` holds:
  - width constants: SEQ_W=12, TLP_W=224, LCRC_W=32, FRAME_W=268, DLLP_W=32
  - `DLLP_TYPE_ACK`/`DLLP_TYPE_NAK`
  - `LCRC_POLY`/`LCRC_INIT`
  - the FSM state enum
- Sub-module `urp_pcie_lcrc32`: combinational CRC-32 over a 236-bit input, 32-bit output. The TX data link layer also uses it for generation.

## Test plan
- **In-order frames:** good frames seq 0,1,2 with `tlp_ready_i`/`dllp_ready_i` tied 1 → three TLPs in order, then DLLPs 32'h00000000, 32'h00000001, 32'h00000002.
- **Bad LCRC:** good seq 0 accepted, then seq 1 with LCRC bit 0 flipped → no TLP, DLLP 32'h10000000, `lcrc_err_cnt_o`=1.
- **NAK suppression:** after that, seq 1 corrupt again → dropped, no DLLP, count=2. Seq 1 good → TLP forwarded, ACK 32'h00000001.
- **Duplicate and future:**
  - After seq 0..4 are received, resend seq 2 → dropped, ACK 32'h00000004.
  - Then send seq 9 → NAK 32'h10000004.
- **Wrap:** preload by streaming 4096 good frames → the last ACK is 32'h00000FFF, then seq 0 is accepted as in-order.
- **Stall and reset:**
  - Hold `tlp_ready_i`=0 for 10 cycles → `tlp_valid_o` and `tlp_o` stay stable and `tlp_data_ready_o`=0.
  - Assert `rst_n` low mid-stall → all outputs return to their reset values on the next sample.
  - Seq 0 is accepted after release.
